digit_scan_mux: RTL and testbench
=================================

// Module: digit_scan_mux
// PURPOSE
//  Parametrised, time-multiplexed N-channel display scanner; successor to the combinational 4:1 nibble mux.
//  Cycles through NUM_CH DATA_W-bit channels at a programmable refresh rate.
//  Drives one active-low anode per channel plus the selected digit value to the 7-segment decoder.
//  Uses double-buffered update (pending -> shadow at frame boundary) so the display never tears mid-frame.
// PARAMETERS
//  NUM_CH       4       channels/digits scanned; legal 1..16
//  DATA_W       4       bits per channel value
//  REFRESH_DIV  100000  clk cycles per digit slot; legal >=1 (1 = advance every cycle)
// PORTS
//  clk          in   1               system clock; all logic rising-edge
//  reset_n      in   1               synchronous, active-low reset
//  en           in   1               scan enable; 0 = display dark, scan frozen
//  data_in      in   NUM_CH*DATA_W   channel i at data_in[i*DATA_W +: DATA_W]
//  upd_req      in   1               1-cycle pulse: capture data_in into pending buffer
//  blank_mask   in   NUM_CH          bit i = 1 keeps anode i off during its slot
//  upd_busy     out  1               pending buffer holds uncommitted data
//  upd_done     out  1               1-cycle pulse: pending committed to shadow
//  frame_start  out  1               1-cycle pulse on slot-tick where channel 0 is selected
//  sel_out      out  clog2(NUM_CH)   channel currently displayed (width 1 when NUM_CH=1)
//  data_out     out  DATA_W          shadow value of the displayed channel
//  anode_n      out  NUM_CH          active-low one-hot anode enables
// BEHAVIOUR
//  Reset (reset_n=0 at edge): prescaler=0, idx=0, pending=shadow=0, upd_busy=0, upd_done=0,
//   frame_start=0, sel_out=0, data_out=0, anode_n=all 1s. Reset wins over every other input.
//  Prescaler: counts 0..REFRESH_DIV-1 while en=1; tick = (count==REFRESH_DIV-1); wraps to 0.
//  On tick (registered, visible next cycle): sel_out<=idx; data_out<=shadow[idx];
//   anode_n<=~(1<<idx), or all 1s if blank_mask[idx]; idx<=idx+1, wrapping NUM_CH-1 -> 0.
//  First tick after reset displays channel 0. Outputs hold between ticks.
//  frame_start pulses together with the output update for idx==0.
//  Update handshake: upd_req -> pending<=data_in, upd_busy=1 next cycle.
//   On a tick with idx==0 and upd_busy=1: shadow<=pending, upd_busy<=0, upd_done pulses 1 cycle.
//   Channel 0 of that frame already shows the new data.
//   upd_req while busy: pending overwritten (last wins); busy stays 1.
//   upd_req in the same cycle as a commit: shadow gets the old pending; new data goes to pending; busy stays 1.
//  en=0: prescaler and idx hold; anode_n<=all 1s next cycle. data_out and sel_out hold.
//   Updates are still captured, but cannot commit.
//   en 0->1: scan resumes at the held idx and prescaler count.
//  NUM_CH=1: idx is constant 0; every tick is a frame_start.
//  blank_mask is sampled on the tick only.
// CONFIGURATION
//  LEAD_ZERO_BLANK_EN defined: at each tick, channel idx is also blanked if shadow[idx]==0
//   and every shadow channel above idx is also 0. Channel 0 is never blanked by this rule.
//  Not defined: blanking comes from blank_mask only; zero digits are displayed.
// STRUCTURE
//  digit_scan_pkg.vh: localparam CH_IDX_W = clog2 helper, ANODE_OFF all-ones constant, clog2 function.
//  Sub-module refresh_prescaler (params DIV; ports clk, reset_n, en, tick) instantiated once.
//  Pending/shadow buffers, idx counter and output registers live in digit_scan_mux.
// TESTING (NUM_CH=4, DATA_W=4, REFRESH_DIV=4 unless noted)
//  1 Reset: hold reset_n=0 5 cycles with en=1 -> anode_n=4'b1111, data_out=0, upd_busy=0; assert reset mid-scan -> same values next cycle.
//  2 Scan: upd_req with data_in=16'h1234; run 2 frames -> after commit, every 4 cycles (anode_n,data_out) = (1110,4),(1101,3),(1011,2),(0111,1); upd_done pulses once.
//  3 Mid-frame update: upd_req 16'hABCD while idx=2 -> slots 2,3 still show 2,1 and upd_busy=1; at next frame_start upd_done=1, then D,C,B,A.
//  4 Enable: drop en during slot 1 -> anode_n=1111 next cycle, sel_out frozen; raise en -> scan continues from the held idx.
//  5 Mask: blank_mask=4'b0100 -> anode_n=1111 during the channel-2 slot; other slots unaffected.
//  6 Macro on, data 16'h0050 -> ch3 and ch2 dark; ch1 shows 5; ch0 shows 0. Macro off -> all four lit.

Source files
------------

// File: rtl/digit_scan_mux_pkg.sv
// Shared constants and helpers for the digit scanner.
// Optional feature macro: LEAD_ZERO_BLANK_EN (see digit_scan_mux.sv).
package digit_scan_mux_pkg;

    localparam int MAX_CH = 16;

    localparam logic [MAX_CH-1:0] ANODE_OFF = '1;

    // Index width that never collapses to zero bits
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_scan_mux_refresh_prescaler.sv
// Slot-rate prescaler: emits one tick every DIV enabled cycles.
// Holds its count while en is low.
module refresh_prescaler
    import digit_scan_mux_pkg::*;
#(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tick
);

    localparam int CW = idx_w(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = en && (count_q == LAST);

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexed N-digit scanner with double-buffered, tear-free updates.
// Define LEAD_ZERO_BLANK_EN to also blank leading zero digits.
module digit_scan_mux
    import digit_scan_mux_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic [NUM_CH*DATA_W-1:0]   data_in,
    input  logic                       upd_req,
    input  logic [NUM_CH-1:0]          blank_mask,
    output logic                       upd_busy,
    output logic                       upd_done,
    output logic                       frame_start,
    output logic [idx_w(NUM_CH)-1:0]   sel_out,
    output logic [DATA_W-1:0]          data_out,
    output logic [NUM_CH-1:0]          anode_n
);

    localparam int CH_IDX_W = idx_w(NUM_CH);
    localparam int BW       = NUM_CH * DATA_W;
    localparam logic [CH_IDX_W-1:0] IDX_LAST = CH_IDX_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0]   OFF      = ANODE_OFF[NUM_CH-1:0];

    logic tick;

    logic [CH_IDX_W-1:0] idx_q, idx_d;
    logic [BW-1:0]       pend_q, pend_d;
    logic [BW-1:0]       shadow_q, shadow_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                fs_q, fs_d;
    logic [CH_IDX_W-1:0] sel_q, sel_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [NUM_CH-1:0]   anode_q, anode_d;

    logic                commit;
    logic [BW-1:0]       eff;
    logic [DATA_W-1:0]   cur;
    logic                lz_blank;
    logic                blank;
    logic [NUM_CH-1:0]   onehot;

    refresh_prescaler #(
        .DIV (REFRESH_DIV)
    ) u_presc (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .tick    (tick)
    );

    // A commit tick must already display the freshly committed frame
    always_comb begin
        commit = tick && (idx_q == '0) && busy_q;
        eff    = commit ? pend_q : shadow_q;
        cur    = eff[int'(idx_q)*DATA_W +: DATA_W];
    end

`ifdef LEAD_ZERO_BLANK_EN
    always_comb begin
        lz_blank = (idx_q != '0);
        for (int i = 0; i < NUM_CH; i++) begin
            if (i >= int'(idx_q) && eff[i*DATA_W +: DATA_W] != '0) begin
                lz_blank = 1'b0;
            end
        end
    end
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        onehot        = '0;
        onehot[idx_q] = 1'b1;
        blank         = blank_mask[idx_q] | lz_blank;
    end

    always_comb begin
        idx_d    = idx_q;
        pend_d   = pend_q;
        shadow_d = shadow_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        fs_d     = 1'b0;
        sel_d    = sel_q;
        dout_d   = dout_q;
        anode_d  = anode_q;

        if (commit) begin
            shadow_d = pend_q;
            busy_d   = 1'b0;
            done_d   = 1'b1;
        end

        // A request racing a commit refills pending and keeps busy set
        if (upd_req) begin
            pend_d = data_in;
            busy_d = 1'b1;
        end

        if (tick) begin
            sel_d   = idx_q;
            dout_d  = cur;
            anode_d = blank ? OFF : ~onehot;
            fs_d    = (idx_q == '0);
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + CH_IDX_W'(1);
        end else if (!en) begin
            anode_d = OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx_q    <= '0;
            pend_q   <= '0;
            shadow_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fs_q     <= 1'b0;
            sel_q    <= '0;
            dout_q   <= '0;
            anode_q  <= OFF;
        end else begin
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            shadow_q <= shadow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fs_q     <= fs_d;
            sel_q    <= sel_d;
            dout_q   <= dout_d;
            anode_q  <= anode_d;
        end
    end

    assign upd_busy    = busy_q;
    assign upd_done    = done_q;
    assign frame_start = fs_q;
    assign sel_out     = sel_q;
    assign data_out    = dout_q;
    assign anode_n     = anode_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Self-checking bench for digit_scan_mux (NUM_CH=4, DATA_W=4, REFRESH_DIV=4).
// Honours LEAD_ZERO_BLANK_EN in its reference model.
module tb_digit_scan_mux;

    localparam int N = 4;
    localparam int W = 4;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] data_in = '0;
    logic        upd_req = 1'b0;
    logic [3:0]  blank_mask = '0;
    logic        upd_busy;
    logic        upd_done;
    logic        frame_start;
    logic [1:0]  sel_out;
    logic [3:0]  data_out;
    logic [3:0]  anode_n;

    int total = 0;
    int bad = 0;

    digit_scan_mux #(
        .NUM_CH      (N),
        .DATA_W      (W),
        .REFRESH_DIV (D)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .data_in     (data_in),
        .upd_req     (upd_req),
        .blank_mask  (blank_mask),
        .upd_busy    (upd_busy),
        .upd_done    (upd_done),
        .frame_start (frame_start),
        .sel_out     (sel_out),
        .data_out    (data_out),
        .anode_n     (anode_n)
    );

    always #5 clk = ~clk;

    // Reference model: slot counter, digit arrays, spec rules in plain arithmetic
    int   m_pres = 0;
    int   m_idx = 0;
    int   m_pend [N] = '{default: 0};
    int   m_shad [N] = '{default: 0};
    bit   m_busy = 0;
    bit   m_done = 0;
    bit   m_fs = 0;
    int   m_sel = 0;
    int   m_dout = 0;
    int   m_lit = -1;

    task automatic model_step();
        bit tick;
        bit blank;
        if (!reset_n) begin
            m_pres = 0; m_idx = 0; m_busy = 0; m_done = 0; m_fs = 0;
            m_sel = 0; m_dout = 0; m_lit = -1;
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0; m_shad[i] = 0;
            end
            return;
        end
        tick = en && (m_pres == D - 1);
        if (en) m_pres = (m_pres + 1) % D;
        m_done = 0;
        m_fs = 0;
        if (tick && m_idx == 0 && m_busy) begin
            m_shad = m_pend;
            m_busy = 0;
            m_done = 1;
        end
        if (upd_req) begin
            for (int i = 0; i < N; i++) m_pend[i] = (data_in >> (4 * i)) & 15;
            m_busy = 1;
        end
        if (tick) begin
            blank = blank_mask[m_idx];
`ifdef LEAD_ZERO_BLANK_EN
            if (m_idx != 0) begin
                bit allz = 1;
                for (int j = m_idx; j < N; j++) if (m_shad[j] != 0) allz = 0;
                if (allz) blank = 1;
            end
`endif
            m_sel = m_idx;
            m_dout = m_shad[m_idx];
            m_lit = blank ? -1 : m_idx;
            m_fs = (m_idx == 0);
            m_idx = (m_idx + 1) % N;
        end else if (!en) begin
            m_lit = -1;
        end
    endtask

    task automatic chk(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_anode();
        logic [3:0] a;
        a = 4'hF;
        if (m_lit >= 0) a[m_lit] = 1'b0;
        return a;
    endfunction

    task automatic cyc();
        logic [12:0] got;
        logic [12:0] exp;
        @(posedge clk);
        model_step();
        #1;
        got = {anode_n, data_out, sel_out, upd_busy, upd_done, frame_start};
        exp = {m_anode(), 4'(m_dout), 2'(m_sel), m_busy, m_done, m_fs};
        chk("model", 16'(got), 16'(exp));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_fs(input int lim);
        int k = 0;
        do begin
            cyc();
            k++;
        end while (!frame_start && k < lim);
        chk("wait_frame_start", 16'(frame_start), 16'd1);
    endtask

    task automatic wait_done(input int lim);
        int k = 0;
        do begin
            cyc();
            k++;
        end while (!upd_done && k < lim);
        chk("wait_upd_done", 16'(upd_done), 16'd1);
    endtask

    typedef struct {
        logic        en;
        logic        req;
        logic [15:0] data;
        logic [3:0]  exp_an;
        logic [3:0]  exp_dat;
        logic        exp_busy;
        logic        exp_done;
    } vec_t;

    vec_t vt [16];
    int   dones;

    initial begin
        // Scan of 16'h1234 right after reset: commit lands on the 4th edge
        vt[0]  = '{1, 1, 16'h1234, 4'b1111, 4'h0, 1, 0};
        vt[1]  = '{1, 0, 16'h0000, 4'b1111, 4'h0, 1, 0};
        vt[2]  = '{1, 0, 16'h0000, 4'b1111, 4'h0, 1, 0};
        vt[3]  = '{1, 0, 16'h0000, 4'b1110, 4'h4, 0, 1};
        vt[4]  = '{1, 0, 16'h0000, 4'b1110, 4'h4, 0, 0};
        vt[5]  = '{1, 0, 16'h0000, 4'b1110, 4'h4, 0, 0};
        vt[6]  = '{1, 0, 16'h0000, 4'b1110, 4'h4, 0, 0};
        vt[7]  = '{1, 0, 16'h0000, 4'b1101, 4'h3, 0, 0};
        vt[8]  = '{1, 0, 16'h0000, 4'b1101, 4'h3, 0, 0};
        vt[9]  = '{1, 0, 16'h0000, 4'b1101, 4'h3, 0, 0};
        vt[10] = '{1, 0, 16'h0000, 4'b1101, 4'h3, 0, 0};
        vt[11] = '{1, 0, 16'h0000, 4'b1011, 4'h2, 0, 0};
        vt[12] = '{1, 0, 16'h0000, 4'b1011, 4'h2, 0, 0};
        vt[13] = '{1, 0, 16'h0000, 4'b1011, 4'h2, 0, 0};
        vt[14] = '{1, 0, 16'h0000, 4'b1011, 4'h2, 0, 0};
        vt[15] = '{1, 0, 16'h0000, 4'b0111, 4'h1, 0, 0};

        // Reset held with en=1
        en = 1'b1;
        reset_n = 1'b0;
        run(5);
        chk("reset_anode", 16'(anode_n), 16'hF);
        chk("reset_data", 16'(data_out), 16'h0);
        chk("reset_busy", 16'(upd_busy), 16'h0);
        reset_n = 1'b1;

        dones = 0;
        for (int r = 0; r < 16; r++) begin
            en = vt[r].en;
            upd_req = vt[r].req;
            data_in = vt[r].data;
            cyc();
            dones += int'(upd_done);
            chk($sformatf("vec%0d", r),
                16'({anode_n, data_out, upd_busy, upd_done}),
                16'({vt[r].exp_an, vt[r].exp_dat, vt[r].exp_busy, vt[r].exp_done}));
        end
        upd_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            dones += int'(upd_done);
        end
        chk("done_pulses", 16'(dones), 16'd1);

        // Mid-frame update while idx==2
        upd_req = 1'b1;
        data_in = 16'hABCD;
        cyc();
        upd_req = 1'b0;
        data_in = '0;
        run(3);
        chk("mid_slot2", 16'({anode_n, data_out, upd_busy}), 16'({4'b1011, 4'h2, 1'b1}));
        run(4);
        chk("mid_slot3", 16'({anode_n, data_out, upd_busy}), 16'({4'b0111, 4'h1, 1'b1}));
        run(4);
        chk("mid_commit", 16'({anode_n, data_out, upd_done, frame_start}),
            16'({4'b1110, 4'hD, 1'b1, 1'b1}));
        run(4);
        chk("mid_ch1", 16'(data_out), 16'hC);
        run(4);
        chk("mid_ch2", 16'(data_out), 16'hB);
        run(4);
        chk("mid_ch3", 16'(data_out), 16'hA);

        // Enable dropped during slot 1
        run(9);
        en = 1'b0;
        cyc();
        chk("en_dark", 16'({anode_n, sel_out}), 16'({4'b1111, 2'd1}));
        run(5);
        chk("en_frozen", 16'({anode_n, sel_out, data_out}), 16'({4'b1111, 2'd1, 4'hC}));
        en = 1'b1;
        run(2);
        chk("en_resume_wait", 16'(anode_n), 16'hF);
        cyc();
        chk("en_resume", 16'({anode_n, sel_out}), 16'({4'b1011, 2'd2}));

        // Blank mask on channel 2 only
        blank_mask = 4'b0100;
        wait_fs(20);
        chk("mask_ch0", 16'(anode_n), 16'({4'b1110}));
        run(8);
        chk("mask_ch2", 16'({anode_n, sel_out}), 16'({4'b1111, 2'd2}));
        run(4);
        chk("mask_ch3", 16'({anode_n, sel_out}), 16'({4'b0111, 2'd3}));
        blank_mask = '0;

        // Leading-zero behaviour with 16'h0050
        upd_req = 1'b1;
        data_in = 16'h0050;
        cyc();
        upd_req = 1'b0;
        wait_done(20);
        chk("lz_ch0", 16'({anode_n, data_out}), 16'({4'b1110, 4'h0}));
        run(4);
        chk("lz_ch1", 16'({anode_n, data_out}), 16'({4'b1101, 4'h5}));
        run(4);
`ifdef LEAD_ZERO_BLANK_EN
        chk("lz_ch2", 16'(anode_n), 16'hF);
        run(4);
        chk("lz_ch3", 16'(anode_n), 16'hF);
`else
        chk("lz_ch2", 16'(anode_n), 16'({4'b1011}));
        run(4);
        chk("lz_ch3", 16'(anode_n), 16'({4'b0111}));
`endif

        // Reset asserted mid-scan with a request pending
        run(2);
        reset_n = 1'b0;
        upd_req = 1'b1;
        data_in = 16'h9999;
        cyc();
        chk("midreset", 16'({anode_n, data_out, sel_out, upd_busy}),
            16'({4'b1111, 4'h0, 2'd0, 1'b0}));
        reset_n = 1'b1;
        upd_req = 1'b0;

        // Randomised traffic against the model
        for (int i = 0; i < 900; i++) begin
            en = ($urandom % 10) != 0;
            upd_req = ($urandom % 12) == 0;
            data_in = 16'($urandom);
            blank_mask = (($urandom % 4) == 0) ? 4'($urandom) : 4'h0;
            reset_n = ($urandom % 300) != 0;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
